// File: rtl/clock_system.sv
// 24-hour clock with alarm, manual time/alarm setting, 12/24-hour BCD outputs
// and a registered 8-digit multiplexed seven-segment scan.
module clock_system #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int FAST_DIV = 50_000,
  parameter int SET_DIV  = 12_500_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk_50m,
  input  logic       cr,
  input  logic       en,
  input  logic [1:0] clock_set_select,
  input  logic [1:0] alarm_set_select,
  input  logic       alarm_en,
  input  logic       ratio_en,
  input  logic       confirm,
  input  logic       day_set,
  output logic       alarm,
  output logic       is_pm,
  output logic [6:0] seg,
  output logic [7:0] pos,
  output logic [7:0] output_hour_day,
  output logic [7:0] output_minute,
  output logic [7:0] output_second
);
  localparam int PW = $clog2(CLK_DIV > FAST_DIV ? CLK_DIV : FAST_DIV) + 1;
  localparam int SW = $clog2(SET_DIV) + 1;
  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam logic [PW-1:0] SLOW_TC = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] FAST_TC = PW'(FAST_DIV - 1);
  localparam logic [SW-1:0] SET_TC  = SW'(SET_DIV - 1);
  localparam logic [DW-1:0] SCAN_TC = DW'(SCAN_DIV - 1);

  logic [PW-1:0] sec_cnt;
  logic [SW-1:0] set_cnt;
  logic [DW-1:0] scan_cnt;
  logic [2:0]    scan_idx, scan_idx_next;
  logic [4:0]    hour, hour_next, alarm_hour, alarm_hour_next, hour_12;
  logic [5:0]    minute, minute_next, second, second_next;
  logic [5:0]    alarm_minute, alarm_minute_next;
  logic [7:0]    disp_h, disp_m, disp_s;
  logic [3:0]    digit;
  logic [6:0]    seg_next;
  logic          sec_tick, set_tick, scan_step, run_mode, alarm_view;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // ">=" rather than "==" so a switch to the shorter divider cannot overrun
  assign sec_tick      = sec_cnt >= (ratio_en ? FAST_TC : SLOW_TC);
  assign set_tick      = set_cnt == SET_TC;
  assign scan_step     = scan_cnt == SCAN_TC;
  assign run_mode      = clock_set_select == 2'b00;
  assign alarm_view    = run_mode && (alarm_set_select != 2'b00);
  assign scan_idx_next = scan_step ? scan_idx + 3'd1 : scan_idx;

  always_comb begin
    hour_next         = hour;
    minute_next       = minute;
    second_next       = second;
    alarm_hour_next   = alarm_hour;
    alarm_minute_next = alarm_minute;
    if (run_mode) begin
      if (en && sec_tick) begin
        if (second == 6'd59) begin
          second_next = 6'd0;
          if (minute == 6'd59) begin
            minute_next = 6'd0;
            hour_next   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end else begin
            minute_next = minute + 6'd1;
          end
        end else begin
          second_next = second + 6'd1;
        end
      end
      case (alarm_set_select)
        2'b01: if (set_tick && confirm)
                 alarm_hour_next = (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
        2'b10: if (set_tick && confirm)
                 alarm_minute_next = (alarm_minute == 6'd59) ? 6'd0 : alarm_minute + 6'd1;
        2'b11: begin
          alarm_hour_next   = 5'd0;
          alarm_minute_next = 6'd0;
        end
        default: ;
      endcase
    end else if (set_tick && confirm) begin
      case (clock_set_select)
        2'b01:   hour_next   = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        2'b10:   minute_next = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
        default: second_next = (second == 6'd59) ? 6'd0 : second + 6'd1;
      endcase
    end
  end

  always_comb begin
    if (hour == 5'd0)       hour_12 = 5'd12;
    else if (hour > 5'd12)  hour_12 = hour - 5'd12;
    else                    hour_12 = hour;
  end

  assign output_hour_day = to_bcd({1'b0, day_set ? hour : hour_12});
  assign output_minute   = to_bcd(minute);
  assign output_second   = to_bcd(second);
  assign is_pm           = hour >= 5'd12;
  assign alarm           = alarm_en && (hour == alarm_hour) && (minute == alarm_minute);

  assign disp_h = alarm_view ? to_bcd({1'b0, alarm_hour}) : output_hour_day;
  assign disp_m = alarm_view ? to_bcd(alarm_minute) : output_minute;
  assign disp_s = alarm_view ? 8'h00 : output_second;

  // Digit code 4'hA stands for the dash separator.
  always_comb begin
    case (scan_idx_next)
      3'd0:    digit = disp_h[7:4];
      3'd1:    digit = disp_h[3:0];
      3'd3:    digit = disp_m[7:4];
      3'd4:    digit = disp_m[3:0];
      3'd6:    digit = disp_s[7:4];
      3'd7:    digit = disp_s[3:0];
      default: digit = 4'hA;
    endcase
  end

  always_comb begin
    case (digit)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk_50m or negedge cr) begin
    if (!cr) begin
      sec_cnt      <= '0;
      set_cnt      <= '0;
      scan_cnt     <= '0;
      scan_idx     <= 3'd0;
      hour         <= 5'd0;
      minute       <= 6'd0;
      second       <= 6'd0;
      alarm_hour   <= 5'd7;
      alarm_minute <= 6'd0;
      pos          <= 8'b0111_1111;
      seg          <= 7'b1000000;
    end else begin
      sec_cnt      <= sec_tick ? '0 : sec_cnt + PW'(1);
      set_cnt      <= set_tick ? '0 : set_cnt + SW'(1);
      scan_cnt     <= scan_step ? '0 : scan_cnt + DW'(1);
      scan_idx     <= scan_idx_next;
      hour         <= hour_next;
      minute       <= minute_next;
      second       <= second_next;
      alarm_hour   <= alarm_hour_next;
      alarm_minute <= alarm_minute_next;
      pos          <= ~(8'h80 >> scan_idx_next);
      seg          <= seg_next;
    end
  end
endmodule

// File: tb/tb_clock_system.sv
// Scoreboard bench for clock_system: a seconds-of-day reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_clock_system;
  localparam int CLK_DIV  = 10;
  localparam int FAST_DIV = 5;
  localparam int SET_DIV  = 4;
  localparam int SCAN_DIV = 2;

  logic       clk_50m = 1'b0;
  logic       cr = 1'b0, en = 1'b0, alarm_en = 1'b0, ratio_en = 1'b0;
  logic       confirm = 1'b0, day_set = 1'b1;
  logic [1:0] clock_set_select = 2'b00, alarm_set_select = 2'b00;
  logic       alarm, is_pm;
  logic [6:0] seg;
  logic [7:0] pos, output_hour_day, output_minute, output_second;

  clock_system #(.CLK_DIV(CLK_DIV), .FAST_DIV(FAST_DIV), .SET_DIV(SET_DIV),
                 .SCAN_DIV(SCAN_DIV)) dut (
    .clk_50m(clk_50m), .cr(cr), .en(en),
    .clock_set_select(clock_set_select), .alarm_set_select(alarm_set_select),
    .alarm_en(alarm_en), .ratio_en(ratio_en), .confirm(confirm), .day_set(day_set),
    .alarm(alarm), .is_pm(is_pm), .seg(seg), .pos(pos),
    .output_hour_day(output_hour_day), .output_minute(output_minute),
    .output_second(output_second)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct {
    logic [7:0] hd, mi, se, pos;
    logic [6:0] seg;
    logic       pm, al, chk_seg;
  } exp_t;

  exp_t sb[$];
  int checks = 0, passed = 0;

  // Reference model: time as seconds of day, alarm as hour/minute, cycle phases.
  int t, ah, am, pc, spc, ssc, sidx;
  bit disp_check = 0;
  logic [6:0] seg_tab [0:10];

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_edge();
    int h, m, s, div;
    bit tick, stick;
    if (!cr) begin
      t = 0; ah = 7; am = 0; pc = 0; spc = 0; ssc = 0; sidx = 0;
      return;
    end
    div   = ratio_en ? FAST_DIV : CLK_DIV;
    tick  = (pc >= div - 1);
    pc    = tick ? 0 : pc + 1;
    stick = (spc == SET_DIV - 1);
    spc   = stick ? 0 : spc + 1;
    if (clock_set_select == 2'b00) begin
      if (en && tick) t = (t + 1) % 86400;
      if (alarm_set_select == 2'b11) begin ah = 0; am = 0; end
      else if (alarm_set_select == 2'b01 && stick && confirm) ah = (ah + 1) % 24;
      else if (alarm_set_select == 2'b10 && stick && confirm) am = (am + 1) % 60;
    end else if (stick && confirm) begin
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      case (clock_set_select)
        2'b01:   h = (h + 1) % 24;
        2'b10:   m = (m + 1) % 60;
        default: s = (s + 1) % 60;
      endcase
      t = h * 3600 + m * 60 + s;
    end
    if (ssc == SCAN_DIV - 1) begin ssc = 0; sidx = (sidx + 1) % 8; end
    else ssc = ssc + 1;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    int h, m, s, hd, dh, dm, ds;
    int dig [8];
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    hd = day_set ? h : (h == 0 ? 12 : (h > 12 ? h - 12 : h));
    if (clock_set_select == 2'b00 && alarm_set_select != 2'b00) begin
      dh = ah; dm = am; ds = 0;
    end else begin
      dh = hd; dm = m; ds = s;
    end
    dig = '{dh / 10, dh % 10, 10, dm / 10, dm % 10, 10, ds / 10, ds % 10};
    e.hd = bcd(hd); e.mi = bcd(m); e.se = bcd(s);
    e.pm = (h >= 12);
    e.al = alarm_en && (h == ah) && (m == am);
    e.pos = ~(8'h80 >> sidx);
    e.seg = seg_tab[dig[sidx]];
    e.chk_seg = disp_check;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk_50m);
    #1;
    model_edge();
    sb.push_back(make_exp());
    @(negedge clk_50m);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_50m);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("hour_day", output_hour_day, e.hd);
        cmp("minute", output_minute, e.mi);
        cmp("second", output_second, e.se);
        cmp("is_pm", {7'd0, is_pm}, {7'd0, e.pm});
        cmp("alarm", {7'd0, alarm}, {7'd0, e.al});
        cmp("pos", pos, e.pos);
        if (e.chk_seg) cmp("seg", {1'b0, seg}, {1'b0, e.seg});
      end
    end
  end

  task automatic set_field(input logic [1:0] sel, input int target);
    int cur;
    clock_set_select = sel;
    alarm_set_select = 2'b00;
    for (int i = 0; i < 300; i++) begin
      cur = (sel == 2'b01) ? t / 3600 : (sel == 2'b10) ? (t / 60) % 60 : t % 60;
      confirm = (cur != target);
      cyc();
    end
    confirm = 1'b0;
    clock_set_select = 2'b00;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_field(2'b01, h);
    set_field(2'b10, m);
    set_field(2'b11, s);
  endtask

  task automatic set_alarm_field(input logic [1:0] sel, input int target);
    clock_set_select = 2'b00;
    alarm_set_select = sel;
    for (int i = 0; i < 300; i++) begin
      confirm = ((sel == 2'b01 ? ah : am) != target);
      cyc();
    end
    confirm = 1'b0;
    alarm_set_select = 2'b00;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F};
    repeat (3) cyc();
    cr = 1'b1; en = 1'b1;
    repeat (25) cyc();

    clock_set_select = 2'b10; confirm = 1'b1;
    repeat (1500) cyc();
    clock_set_select = 2'b11;
    repeat (40) cyc();
    confirm = 1'b0; clock_set_select = 2'b00;

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) clock_set_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) alarm_set_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) ratio_en = ~ratio_en;
      if ($urandom_range(0, 31) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 7) == 0) day_set = ~day_set;
      confirm = 1'($urandom_range(0, 1));
      cyc();
    end
    clock_set_select = 2'b00; alarm_set_select = 2'b00; confirm = 1'b0;
    ratio_en = 1'b0; en = 1'b1; alarm_en = 1'b0; day_set = 1'b1;

    set_time(23, 59, 59);
    repeat (12) cyc();

    alarm_set_select = 2'b11;
    cyc();
    set_alarm_field(2'b01, 0);
    set_alarm_field(2'b10, 1);
    alarm_en = 1'b1; ratio_en = 1'b1;
    repeat (700) cyc();
    set_time(0, 1, 30);
    en = 1'b0; alarm_en = 1'b0;
    repeat (3) cyc();
    alarm_en = 1'b1;
    repeat (3) cyc();
    en = 1'b1; ratio_en = 1'b0;

    day_set = 1'b0;
    set_field(2'b01, 13);
    repeat (4) cyc();
    set_field(2'b01, 0);
    repeat (4) cyc();
    day_set = 1'b1;

    en = 1'b0;
    set_time(12, 34, 56);
    repeat (4) cyc();
    disp_check = 1;
    repeat (40) cyc();
    disp_check = 0;
    alarm_set_select = 2'b01;
    repeat (4) cyc();
    disp_check = 1;
    repeat (20) cyc();
    disp_check = 0;
    alarm_set_select = 2'b00;

    @(negedge clk_50m);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
